// File: rtl/mem_arbiter.sv
// mem_arbiter: cache-side memory arbiter between the L1 instruction cache,
// the L1 data cache and a single-port RAM. One word access at a time. The
// data cache wins ties, but after STARVE_LIMIT consecutive D grants with an
// I request waiting, the next grant goes to the instruction cache.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   iREN, iaddr          icache read request and word address
//   iwait, iload         icache stall (0 for one cycle = done) and read data
//   dREN, dWEN           dcache read / write request (write wins if both)
//   daddr, dstore        dcache word address and write data
//   dwait, dload         dcache stall (0 for one cycle = done) and read data
//   ramREN, ramWEN       RAM read / write enables
//   ramaddr, ramstore    RAM address and write data
//   ramload, ramready    RAM read data and access-complete strobe
//
// STARVE_LIMIT must be at least 1.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready
);

    localparam int unsigned AW = 32;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DACCESS = 2'd1,
        IACCESS = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [SW-1:0]   streak, streak_n;
    logic [AW-1:0]   req_addr, req_addr_n;
    logic [AW-1:0]   req_data, req_data_n;
    logic            req_wr, req_wr_n;

    logic            d_req;
    logic            starved;
    logic [SW-1:0]   streak_inc;

    assign d_req      = dREN | dWEN;
    assign starved    = iREN && (streak == SW'(STARVE_LIMIT));
    // Saturating increment; the forced I grant normally keeps it at or below the limit.
    assign streak_inc = (streak == SW'(STARVE_LIMIT)) ? streak : streak + SW'(1);

    // State and latched request registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            streak   <= '0;
            req_addr <= '0;
            req_data <= '0;
            req_wr   <= 1'b0;
        end else begin
            state    <= state_n;
            streak   <= streak_n;
            req_addr <= req_addr_n;
            req_data <= req_data_n;
            req_wr   <= req_wr_n;
        end
    end

    // Grant decision, request latching and output decode
    always_comb begin
        state_n    = state;
        streak_n   = streak;
        req_addr_n = req_addr;
        req_data_n = req_data;
        req_wr_n   = req_wr;

        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;

        unique case (state)
            IDLE: begin
                if (!iREN) begin
                    streak_n = '0;
                end
                if (starved) begin
                    state_n    = IACCESS;
                    req_addr_n = iaddr;
                    req_data_n = '0;
                    req_wr_n   = 1'b0;
                    streak_n   = '0;
                end else if (d_req) begin
                    state_n    = DACCESS;
                    req_addr_n = daddr;
                    req_data_n = dstore;
                    req_wr_n   = dWEN;
                    if (iREN) begin
                        streak_n = streak_inc;
                    end
                end else if (iREN) begin
                    state_n    = IACCESS;
                    req_addr_n = iaddr;
                    req_data_n = '0;
                    req_wr_n   = 1'b0;
                    streak_n   = '0;
                end
            end
            DACCESS: begin
                // Completion takes precedence; otherwise a dropped request aborts quietly.
                if (ramready || !d_req) begin
                    state_n = IDLE;
                end
            end
            IACCESS: begin
                if (ramready || !iREN) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // RAM side follows only the registered state and latched request.
        if (state != IDLE) begin
            ramREN   = !req_wr;
            ramWEN   = req_wr;
            ramaddr  = req_addr;
            ramstore = req_wr ? req_data : '0;
        end

        if ((state == DACCESS) && ramready) begin
            dwait = 1'b0;
            dload = req_wr ? '0 : ramload;
        end

        if ((state == IACCESS) && ramready) begin
            iwait = 1'b0;
            iload = ramload;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vector table, hand-written multi-cycle
// sequences (reset mid-access, starvation guard, abort), and a randomized run
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramready (ramready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        iren;
        logic [31:0] iad;
        logic        dren;
        logic        dwen;
        logic [31:0] dad;
        logic [31:0] dst;
        logic [31:0] rld;
        logic        rrdy;
        logic        e_iw;
        logic        e_dw;
        logic [31:0] e_il;
        logic [31:0] e_dl;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_ra;
        logic [31:0] e_rs;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw,
                                logic [31:0] da, logic [31:0] ds, logic [31:0] rl, logic rr,
                                logic eiw, logic edw, logic [31:0] eil, logic [31:0] edl,
                                logic er, logic ew, logic [31:0] era, logic [31:0] ers);
        vec_t v;
        v.iren = ir;  v.iad = ia;  v.dren = dr;  v.dwen = dw;
        v.dad = da;   v.dst = ds;  v.rld = rl;   v.rrdy = rr;
        v.e_iw = eiw; v.e_dw = edw; v.e_il = eil; v.e_dl = edl;
        v.e_ren = er; v.e_wen = ew; v.e_ra = era; v.e_rs = ers;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_iw, input logic e_dw,
                           input logic [31:0] e_il, input logic [31:0] e_dl,
                           input logic e_ren, input logic e_wen,
                           input logic [31:0] e_ra, input logic [31:0] e_rs);
        chk({tag, ".iwait"},    32'(iwait),  32'(e_iw));
        chk({tag, ".dwait"},    32'(dwait),  32'(e_dw));
        chk({tag, ".iload"},    iload,       e_il);
        chk({tag, ".dload"},    dload,       e_dl);
        chk({tag, ".ramREN"},   32'(ramREN), 32'(e_ren));
        chk({tag, ".ramWEN"},   32'(ramWEN), 32'(e_wen));
        chk({tag, ".ramaddr"},  ramaddr,     e_ra);
        chk({tag, ".ramstore"}, ramstore,    e_rs);
    endtask

    task automatic clear_inputs();
        iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramready = 1'b0;
    endtask

    // Leaves the bench at posedge+1 with the DUT in its reset state.
    task automatic do_reset();
        clear_inputs();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Reference model state (transaction level)
    int          m_owner;   // 0 none, 1 dcache, 2 icache
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic        m_wr;
    int          m_dstreak; // D grants in a row while an I request waited

    // Randomized requester state
    logic d_act, d_rd, d_wr, i_act, d_ab, i_ab;
    logic last_dwait, last_iwait;

    int got[$];
    int exp_order[6];
    int gv;

    initial begin
        nRST = 1'b0;
        clear_inputs();

        // ---------------- Directed vector table ----------------
        vecs[0]  = mk(0, 0, 0, 0, 0,          0,           0,            0, 1, 1, 0,            0,            0, 0, 0,          0);
        vecs[1]  = mk(0, 0, 1, 0, 32'h100,    0,           0,            0, 1, 1, 0,            0,            0, 0, 0,          0);
        vecs[2]  = mk(0, 0, 1, 0, 32'h100,    0,           0,            0, 1, 1, 0,            0,            1, 0, 32'h100,    0);
        vecs[3]  = mk(0, 0, 1, 0, 32'h100,    0,           0,            0, 1, 1, 0,            0,            1, 0, 32'h100,    0);
        vecs[4]  = mk(0, 0, 1, 0, 32'h100,    0,           32'hDEADBEEF, 1, 1, 0, 0,            32'hDEADBEEF, 1, 0, 32'h100,    0);
        vecs[5]  = mk(0, 0, 0, 0, 0,          0,           0,            0, 1, 1, 0,            0,            0, 0, 0,          0);
        vecs[6]  = mk(1, 0, 0, 1, 32'h200,    32'h12345678, 0,           0, 1, 1, 0,            0,            0, 0, 0,          0);
        vecs[7]  = mk(1, 0, 0, 1, 32'h200,    32'h12345678, 0,           0, 1, 1, 0,            0,            0, 1, 32'h200,    32'h12345678);
        vecs[8]  = mk(1, 0, 0, 1, 32'h200,    32'h12345678, 32'hAAAA5555, 1, 1, 0, 0,           0,            0, 1, 32'h200,    32'h12345678);
        vecs[9]  = mk(1, 0, 0, 0, 0,          0,           0,            0, 1, 1, 0,            0,            0, 0, 0,          0);
        vecs[10] = mk(1, 0, 0, 0, 0,          0,           32'h0BADF00D, 1, 0, 1, 32'h0BADF00D, 0,            1, 0, 0,          0);
        vecs[11] = mk(0, 0, 0, 0, 0,          0,           0,            0, 1, 1, 0,            0,            0, 0, 0,          0);
        vecs[12] = mk(0, 0, 1, 1, 32'h300,    32'h55,      0,            0, 1, 1, 0,            0,            0, 0, 0,          0);
        vecs[13] = mk(0, 0, 1, 1, 32'h300,    32'h55,      32'h77,       1, 1, 0, 0,            0,            0, 1, 32'h300,    32'h55);
        vecs[14] = mk(0, 0, 0, 0, 0,          0,           32'h99,       1, 1, 1, 0,            0,            0, 0, 0,          0);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            iREN = vecs[i].iren; iaddr = vecs[i].iad;
            dREN = vecs[i].dren; dWEN = vecs[i].dwen;
            daddr = vecs[i].dad; dstore = vecs[i].dst;
            ramload = vecs[i].rld; ramready = vecs[i].rrdy;
            @(negedge CLK);
            chk_all($sformatf("vec%0d", i), vecs[i].e_iw, vecs[i].e_dw, vecs[i].e_il, vecs[i].e_dl,
                    vecs[i].e_ren, vecs[i].e_wen, vecs[i].e_ra, vecs[i].e_rs);
            next_cycle();
        end

        // ---------------- Reset in the middle of a D write ----------------
        do_reset();
        dWEN = 1'b1; daddr = 32'h40; dstore = 32'hCAFE0001;
        next_cycle();
        @(negedge CLK);
        chk("rst_mid.ramWEN_before", 32'(ramWEN), 32'd1);
        nRST = 1'b0;
        #1;
        chk("rst_mid.ramWEN_async", 32'(ramWEN), 32'd0);
        chk("rst_mid.ramaddr_async", ramaddr, 32'd0);
        chk("rst_mid.dwait_async", 32'(dwait), 32'd1);
        clear_inputs();
        next_cycle();
        nRST = 1'b1;
        @(negedge CLK);
        chk_all("rst_mid.after", 1, 1, 0, 0, 0, 0, 0, 0);
        next_cycle();

        // ---------------- Starvation guard ----------------
        do_reset();
        dREN = 1'b1; daddr = 32'hD0; iREN = 1'b1; iaddr = 32'h10;
        ramready = 1'b1; ramload = 32'h5;
        got.delete();
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (ramREN) begin
                gv = (ramaddr == 32'h10) ? 1 : 0;
                got.push_back(gv);
                if (gv == 1) chk("starve.streak_after_i", 32'(dut.streak), 32'd0);
            end
            next_cycle();
        end
        exp_order = '{0, 0, 0, 0, 1, 0};
        chk("starve.grant_count", 32'(got.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("starve.grant%0d_is_i", k), (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF,
                32'(exp_order[k]));
        end

        // ---------------- Abort of a D read, pending I then served ----------------
        do_reset();
        dREN = 1'b1; daddr = 32'h500; iREN = 1'b1; iaddr = 32'h600;
        @(negedge CLK);
        next_cycle();
        dREN = 1'b0;
        @(negedge CLK);
        chk("abort.dwait_in_access", 32'(dwait), 32'd1);
        chk("abort.ramaddr_in_access", ramaddr, 32'h500);
        next_cycle();
        @(negedge CLK);
        chk_all("abort.idle", 1, 1, 0, 0, 0, 0, 0, 0);
        next_cycle();
        ramready = 1'b1; ramload = 32'h1234ABCD;
        @(negedge CLK);
        chk_all("abort.i_grant", 0, 1, 32'h1234ABCD, 0, 1, 0, 32'h600, 0);
        next_cycle();

        // ---------------- Randomized run against reference model ----------------
        do_reset();
        m_owner = 0; m_addr = '0; m_data = '0; m_wr = 1'b0; m_dstreak = 0;
        d_act = 1'b0; d_rd = 1'b0; d_wr = 1'b0; i_act = 1'b0;
        last_dwait = 1'b1; last_iwait = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            d_ab = 1'b0;
            i_ab = 1'b0;
            if (d_act) begin
                if (!last_dwait) d_act = 1'b0;
                else if ($urandom_range(39) == 0) begin d_act = 1'b0; d_ab = 1'b1; end
            end else if ($urandom_range(2) == 0) begin
                gv = int'($urandom_range(2));
                d_act = 1'b1; d_rd = (gv != 1); d_wr = (gv != 0);
                daddr = $urandom; dstore = $urandom;
                last_dwait = 1'b1;
            end
            if (i_act) begin
                if (!last_iwait) i_act = 1'b0;
                else if ($urandom_range(39) == 0) begin i_act = 1'b0; i_ab = 1'b1; end
            end else if ($urandom_range(2) == 0) begin
                i_act = 1'b1; iaddr = $urandom;
                last_iwait = 1'b1;
            end
            dREN = d_act & d_rd;
            dWEN = d_act & d_wr;
            iREN = i_act;
            ramready = (d_ab || i_ab) ? 1'b0 : 1'($urandom_range(1));
            ramload = $urandom;

            @(negedge CLK);
            chk_all($sformatf("rnd%0d", cyc),
                    !(m_owner == 2 && ramready),
                    !(m_owner == 1 && ramready),
                    (m_owner == 2 && ramready) ? ramload : 32'd0,
                    (m_owner == 1 && ramready && !m_wr) ? ramload : 32'd0,
                    (m_owner != 0) && !m_wr,
                    (m_owner != 0) && m_wr,
                    (m_owner != 0) ? m_addr : 32'd0,
                    (m_owner != 0 && m_wr) ? m_data : 32'd0);
            last_dwait = dwait;
            last_iwait = iwait;

            // Model: who owns the RAM next cycle
            if (m_owner == 0) begin
                if (iREN && m_dstreak >= int'(LIMIT)) begin
                    m_owner = 2; m_addr = iaddr; m_wr = 1'b0; m_dstreak = 0;
                end else if (dREN || dWEN) begin
                    m_owner = 1; m_addr = daddr; m_data = dstore; m_wr = dWEN;
                    m_dstreak = iREN ? ((m_dstreak + 1 > int'(LIMIT)) ? int'(LIMIT) : m_dstreak + 1) : 0;
                end else if (iREN) begin
                    m_owner = 2; m_addr = iaddr; m_wr = 1'b0; m_dstreak = 0;
                end else begin
                    m_dstreak = 0;
                end
            end else if (ramready) begin
                m_owner = 0;
            end else if (m_owner == 1 && !(dREN || dWEN)) begin
                m_owner = 0;
            end else if (m_owner == 2 && !iREN) begin
                m_owner = 0;
            end
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Cache-side responder for the cache control interface. Accepts word requests from the instruction cache (read-only) and the data cache (read/write), grants one at a time to a single-port RAM, and returns data and `wait` release to the granted requester. Sits between the two L1 caches and the RAM model in the memory subsystem. The data cache has priority, and a bounded starvation guard protects instruction fetch.

## Interface
- `STARVE_LIMIT`, default 4: maximum consecutive D grants while an I request is pending; the next grant is forced to I.
- `CLK  in  1`: clock.
- `nRST  in  1`: reset, asynchronous, active-low.
- `iREN  in  1`: icache read request.
- `iaddr  in  32`: icache word address.
- `iwait  out  1`: icache stall; 0 for one cycle marks completion.
- `iload  out  32`: icache read data, valid when `iwait`=0.
- `dREN  in  1`: dcache read request.
- `dWEN  in  1`: dcache write request.
- `daddr  in  32`: dcache word address.
- `dstore  in  32`: dcache write data.
- `dwait  out  1`: dcache stall; 0 for one cycle marks completion.
- `dload  out  32`: dcache read data, valid when `dwait`=0.
- `ramREN  out  1`: RAM read enable.
- `ramWEN  out  1`: RAM write enable.
- `ramaddr  out  32`: RAM address.
- `ramstore  out  32`: RAM write data.
- `ramload  in  32`: RAM read data, valid with `ramready`.
- `ramready  in  1`: RAM access complete this cycle. Ignored unless an access is active.

## Operation
- States: IDLE, DACCESS, IACCESS.
- IDLE grant decision, first matching rule wins:
  - `streak`==STARVE_LIMIT and `iREN` -> IACCESS.
  - `dREN`|`dWEN` -> DACCESS.
  - `iREN` -> IACCESS.
  - Otherwise stay in IDLE.
- On grant, latch address, data, and write flag into `req_addr`, `req_data`, `req_wr`.
  - I grants: `req_wr`=0.
  - D grants: `req_wr`=`dWEN`. If `dREN` and `dWEN` are both asserted, the write wins.
- Streak counter (clog2(STARVE_LIMIT+1) bits, saturating):
  - On a D grant with `iREN` high: +1.
  - On an I grant, or any IDLE cycle with `iREN` low: cleared to 0.
- In DACCESS/IACCESS:
  - `ramREN`=!`req_wr`, `ramWEN`=`req_wr`, `ramaddr`=`req_addr`, `ramstore`=`req_data` (0 on reads).
  - When `ramready`=1: drive the granted `*wait`=0 and `*load`=`ramload` (reads only; 0 on writes). Next state IDLE.
- Abort: if the granted requester drops its enable(s) before `ramready`, go to IDLE next cycle. No `wait` release and no data are returned, and the streak is unchanged.
- The non-granted requester sees `*wait`=1 throughout.
- `*load` is 0 whenever the corresponding `*wait`=1.

## Timing
- Reset values:
  - State IDLE, `streak`=0, `req_*`=0.
  - `iwait`=`dwait`=1.
  - `iload`=`dload`=0.
  - `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0.
- Outputs are a combinational decode of state, latched request, and `ramready`. RAM control outputs depend only on registered state.
- Request seen in IDLE at cycle t -> RAM enables asserted at t+1. With `ramready` at t+1+k, `wait`=0 at t+1+k. Minimum latency is 2 cycles (k=0).
- Back-to-back: at least one IDLE cycle between transactions. Maximum throughput is one word per 2 cycles.
- Requesters hold enable, address, and data until their `wait` drops. Later changes to address or data are ignored because the block uses latched copies.
- `ramready` outside an access state produces no effect.
- nRST asserted mid-access: immediate return to reset values, `wait` stays 1, and the RAM enables drop asynchronously.

## Test plan
- Reset mid-DACCESS write (`daddr`=0x40, `ramready` withheld) -> `ramWEN` drops immediately. After release, state is IDLE and `dwait`=`iwait`=1.
- Lone dcache read of 0x100, `ramready` 2 cycles after `ramREN` -> `ramREN`=1 at t+1, `dwait`=0 with `dload`=`ramload`=0xDEADBEEF at t+3 for one cycle. Back in IDLE at t+4.
- Simultaneous `iREN` (0x0) and `dWEN` (0x200, 0x12345678) -> D granted first with `ramWEN`=1, `ramstore`=0x12345678. I is served next, and `iwait` stays 1 until then.
- Continuous `dREN` plus `iREN`, `ramready` immediate, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D…, and `streak` returns to 0 after the I grant.
- `dREN` dropped one cycle after grant before `ramready` -> state IDLE next cycle, `dwait` never 0, and a pending `iREN` is then granted.
- `dREN` and `dWEN` both high -> treated as a write: `ramWEN`=1, `ramREN`=0, `dload`=0 on completion.
